tile_scheduler: RTL and testbench
=================================

# tile_scheduler

Game-sequencing controller for the falling-tile play field. It consumes the tick pulse from the scaling rate divider, holds that divider in reset outside active play, and scrolls a LANES×ROWS tile grid one row per tick. It spawns new tiles from an LFSR, resolves key hits against the bottom hit window, keeps score, and detects the game-over condition. Outputs feed the VGA renderer and score display.

## Interface
- LANES, 4, number of key lanes (columns); fixed at 4 in this revision
- ROWS, 8, visible rows per lane; row 0 is the top, row ROWS-1 the bottom
- SPAWN_GAP, 2, ticks between tile spawns (≥1)
- LFSR_SEED, 8'hA5, non-zero LFSR reset value

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; all state to reset values immediately
- start  in  1  one-cycle pulse; begins or restarts a game
- tick  in  1  one-cycle scroll pulse from the rate divider
- key  in  LANES  one-cycle hit pulses, bit i = lane i
- rate_reset  out  1  drives the rate divider's reset
- grid  out  LANES*ROWS  tile occupancy; bit lane*ROWS+row
- score  out  16  hits this game
- state  out  2  0=IDLE, 1=PLAY, 2=OVER
- game_over  out  1  high while state==OVER

## Operation
- Reset values:
  - state=IDLE, grid=0, score=0
  - rate_reset=1, game_over=0
  - LFSR=LFSR_SEED, gap counter=0
- IDLE:
  - start → PLAY
  - grid, score and gap counter cleared on entry to PLAY
- PLAY:
  - rate_reset=0
  - tick and key are ignored in every state except PLAY
- OVER:
  - grid and score frozen; rate_reset=1
  - start → PLAY, with grid, score and gap counter cleared
  - LFSR is not reseeded, so each game differs
- Key resolution (PLAY, any cycle), per lane i with key[i]=1, evaluated on the current grid:
  - Hit window is rows ROWS-1 and ROWS-2.
  - If lane i has a tile in the window, clear the lower one (ROWS-1 first). That lane counts as one hit.
  - If the window is empty, the key is a wrong key; see Configuration.
  - Lanes are independent. score += hit count, saturating at 16'hFFFF.
- Tick processing (PLAY, tick=1), applied to the post-key grid:
  - Any tile in row ROWS-1 → miss; state→OVER, and the grid is not shifted.
  - Otherwise every lane shifts down one row and row 0 is loaded.
  - If gap counter == SPAWN_GAP-1: row 0 = one-hot lane LFSR[1:0], gap counter → 0.
  - Else: row 0 = 0 and gap counter increments.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4; shift left, feedback into bit 0.
  - Advances on every PLAY tick.
- Simultaneous events:
  - A key and a tick in the same cycle: the key is resolved first, so hitting the bottom tile on the tick cycle avoids the miss.
  - start in PLAY is ignored.
  - start together with tick in IDLE or OVER: start wins; the tick is dropped.

## Timing
- All outputs are registered.
- grid, score and state update on the clk edge that samples tick/key/start (1-cycle latency).
- rate_reset and game_over are registered from state, so they change in the same cycle as state.
- After start, rate_reset falls on the next edge. The first tick arrives one divider period later.
- Asynchronous reset asserted mid-game forces reset values without waiting for clk. The first action after release requires start.

## Configuration
- STRICT_KEY_EN
  - Defined: a wrong key in PLAY → OVER on that edge. The keyed lanes that hit in the same cycle still score, and the tick is not applied.
  - Undefined: wrong keys are ignored, with no penalty.

## Test plan
- After reset: grid=0, score=0, state=0, rate_reset=1. Then start → state=1, rate_reset=0 on the next edge.
- SPAWN_GAP=2, LFSR_SEED=8'hA5, 4 ticks: a tile appears in row 0 on the 2nd and 4th ticks, in lane LFSR[1:0]. Each tile moves down one row per tick.
- Tile in lane 2, row 7; key=4'b0100 and tick in the same cycle → score=1, no OVER, grid shifts.
- Tile in row 7 and a tick with no key → state=2, game_over=1, rate_reset=1, grid unchanged. Then start → grid=0, score=0, state=1.
- key=4'b0001 with lane 0's window empty: with STRICT_KEY_EN → state=2; without it → state stays 1, score unchanged.
- Score preset near saturation by 65535 hits (or a forced register): a further hit keeps score=16'hFFFF. Reset asserted mid-game → all outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/tile_scheduler.sv
// rtl/tile_scheduler.sv - falling-tile game sequencer: scroll, spawn, key hits, score, game over
// Optional STRICT_KEY_EN: a key pressed into an empty hit window ends the game.
module tile_scheduler #(
  parameter int         LANES     = 4,
  parameter int         ROWS      = 8,
  parameter int         SPAWN_GAP = 2,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  tick,
  input  logic [LANES-1:0]      key,
  output logic                  rate_reset,
  output logic [LANES*ROWS-1:0] grid,
  output logic [15:0]           score,
  output logic [1:0]            state,
  output logic                  game_over
);

  localparam int GW = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam int HW = $clog2(LANES + 1);
`ifdef STRICT_KEY_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [LANES*ROWS-1:0]   grid_q, grid_d, key_grid;
  logic [15:0]             score_q, score_d, score_sat;
  logic [16:0]             score_sum;
  logic [GW-1:0]           gap_q, gap_d;
  logic [7:0]              lfsr_q, lfsr_d;
  logic [HW-1:0]           hit_cnt;
  logic                    wrong_key, miss, spawn, fb;
  logic                    rate_reset_q, game_over_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grid_q       <= '0;
      score_q      <= '0;
      gap_q        <= '0;
      lfsr_q       <= LFSR_SEED;
      rate_reset_q <= 1'b1;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grid_q       <= grid_d;
      score_q      <= score_d;
      gap_q        <= gap_d;
      lfsr_q       <= lfsr_d;
      rate_reset_q <= (state_d != PLAY);
      game_over_q  <= (state_d == OVER);
    end
  end

  always_comb begin
    state_d   = state_q;
    grid_d    = grid_q;
    score_d   = score_q;
    gap_d     = gap_q;
    lfsr_d    = lfsr_q;
    key_grid  = grid_q;
    hit_cnt   = '0;
    wrong_key = 1'b0;
    miss      = 1'b0;
    spawn     = (gap_q == GW'(SPAWN_GAP - 1));
    fb        = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    // Keys resolve against the current grid before any scroll, lowest row first.
    for (int l = 0; l < LANES; l++) begin
      if (key[l]) begin
        if (grid_q[l*ROWS + ROWS-1]) begin
          key_grid[l*ROWS + ROWS-1] = 1'b0;
          hit_cnt = hit_cnt + HW'(1);
        end else if (grid_q[l*ROWS + ROWS-2]) begin
          key_grid[l*ROWS + ROWS-2] = 1'b0;
          hit_cnt = hit_cnt + HW'(1);
        end else begin
          wrong_key = 1'b1;
        end
      end
      miss = miss | key_grid[l*ROWS + ROWS-1];
    end

    score_sum = {1'b0, score_q} + 17'(hit_cnt);
    score_sat = score_sum[16] ? 16'hFFFF : score_sum[15:0];

    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d = PLAY;
          grid_d  = '0;
          score_d = '0;
          gap_d   = '0;
        end
      end
      PLAY: begin
        grid_d  = key_grid;
        score_d = score_sat;
        if (STRICT && wrong_key) begin
          state_d = OVER;
        end else if (tick) begin
          lfsr_d = {lfsr_q[6:0], fb};
          if (miss) begin
            state_d = OVER;
          end else begin
            for (int l = 0; l < LANES; l++) begin
              grid_d[l*ROWS +: ROWS] = {key_grid[l*ROWS +: ROWS-1],
                                        spawn && (lfsr_q[1:0] == 2'(l))};
            end
            gap_d = spawn ? '0 : gap_q + GW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rate_reset = rate_reset_q;
  assign game_over  = game_over_q;
  assign grid       = grid_q;
  assign score      = score_q;
  assign state      = state_q;

endmodule

// File: tb/tb_tile_scheduler.sv
// tb/tb_tile_scheduler.sv - directed bench for tile_scheduler (default parameters)
module tb_tile_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        tick = 1'b0;
  logic [3:0]  key = 4'h0;
  logic        rate_reset;
  logic [31:0] grid;
  logic [15:0] score;
  logic [1:0]  state;
  logic        game_over;

  int errors = 0;
  int checks = 0;

  tile_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .tick       (tick),
    .key        (key),
    .rate_reset (rate_reset),
    .grid       (grid),
    .score      (score),
    .state      (state),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  task automatic cycle(input logic s, input logic t, input logic [3:0] k);
    @(negedge clk);
    start = s; tick = t; key = k;
    @(posedge clk);
    #1;
    start = 1'b0; tick = 1'b0; key = 4'h0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (grid !== 32'h0) begin errors++; $display("FAIL reset_grid got %h exp %h", grid, 32'h0); end
    checks++; if (score !== 16'h0) begin errors++; $display("FAIL reset_score got %h exp %h", score, 16'h0); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (rate_reset !== 1'b1) begin errors++; $display("FAIL reset_rate_reset got %b exp 1", rate_reset); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over got %b exp 0", game_over); end
    cycle(1'b0, 1'b1, 4'hF);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_ignores_tick state got %0d exp 0", state); end
    checks++; if (grid !== 32'h0) begin errors++; $display("FAIL idle_ignores_tick grid got %h exp 0", grid); end
  endtask

  task automatic test_start();
    cycle(1'b1, 1'b1, 4'h0);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_state got %0d exp 1", state); end
    checks++; if (rate_reset !== 1'b0) begin errors++; $display("FAIL start_rate_reset got %b exp 0", rate_reset); end
    checks++; if (grid !== 32'h0) begin errors++; $display("FAIL start_tick_dropped grid got %h exp 0", grid); end
    cycle(1'b1, 1'b0, 4'h0);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_in_play state got %0d exp 1", state); end
  endtask

  task automatic test_spawn();
    logic [31:0] exp_grid [4];
    exp_grid[0] = 32'h0000_0000;
    exp_grid[1] = 32'h0001_0000;
    exp_grid[2] = 32'h0002_0000;
    exp_grid[3] = 32'h0005_0000;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 4'h0);
      checks++;
      if (grid !== exp_grid[i]) begin
        errors++; $display("FAIL spawn_tick%0d grid got %h exp %h", i + 1, grid, exp_grid[i]);
      end
    end
  endtask

  task automatic test_key_on_tick();
    repeat (5) cycle(1'b0, 1'b1, 4'h0);
    checks++; if (grid !== 32'h02A0_0800) begin errors++; $display("FAIL pre_hit grid got %h exp %h", grid, 32'h02A0_0800); end
    cycle(1'b0, 1'b1, 4'b0100);
    checks++; if (score !== 16'd1) begin errors++; $display("FAIL key_tick_score got %0d exp 1", score); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL key_tick_state got %0d exp 1", state); end
    checks++; if (grid !== 32'h0440_1100) begin errors++; $display("FAIL key_tick_grid got %h exp %h", grid, 32'h0440_1100); end
  endtask

  task automatic test_miss();
    cycle(1'b0, 1'b1, 4'h0);
    checks++; if (grid !== 32'h0880_2200) begin errors++; $display("FAIL pre_miss grid got %h exp %h", grid, 32'h0880_2200); end
    cycle(1'b0, 1'b1, 4'h0);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL miss_state got %0d exp 2", state); end
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL miss_game_over got %b exp 1", game_over); end
    checks++; if (rate_reset !== 1'b1) begin errors++; $display("FAIL miss_rate_reset got %b exp 1", rate_reset); end
    checks++; if (grid !== 32'h0880_2200) begin errors++; $display("FAIL miss_grid got %h exp %h", grid, 32'h0880_2200); end
    cycle(1'b0, 1'b1, 4'hF);
    checks++; if (grid !== 32'h0880_2200) begin errors++; $display("FAIL over_frozen grid got %h exp %h", grid, 32'h0880_2200); end
    checks++; if (score !== 16'd1) begin errors++; $display("FAIL over_frozen score got %0d exp 1", score); end
    cycle(1'b1, 1'b0, 4'h0);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL restart_state got %0d exp 1", state); end
    checks++; if (grid !== 32'h0) begin errors++; $display("FAIL restart_grid got %h exp 0", grid); end
    checks++; if (score !== 16'd0) begin errors++; $display("FAIL restart_score got %0d exp 0", score); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL restart_game_over got %b exp 0", game_over); end
  endtask

  task automatic test_wrong_key();
    logic [1:0] exp_state;
`ifdef STRICT_KEY_EN
    exp_state = 2'd2;
`else
    exp_state = 2'd1;
`endif
    cycle(1'b0, 1'b0, 4'b0001);
    checks++; if (state !== exp_state) begin errors++; $display("FAIL wrong_key_state got %0d exp %0d", state, exp_state); end
    checks++; if (score !== 16'd0) begin errors++; $display("FAIL wrong_key_score got %0d exp 0", score); end
    cycle(1'b1, 1'b0, 4'h0);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL wrong_key_resume got %0d exp 1", state); end
  endtask

  task automatic test_window_row6();
    repeat (8) cycle(1'b0, 1'b1, 4'h0);
    checks++; if (grid !== 32'h0110_4400) begin errors++; $display("FAIL pre_row6 grid got %h exp %h", grid, 32'h0110_4400); end
    cycle(1'b0, 1'b0, 4'b0010);
    checks++; if (grid !== 32'h0110_0400) begin errors++; $display("FAIL row6_hit grid got %h exp %h", grid, 32'h0110_0400); end
    checks++; if (score !== 16'd1) begin errors++; $display("FAIL row6_hit score got %0d exp 1", score); end
  endtask

  task automatic test_saturation();
    repeat (3) cycle(1'b0, 1'b1, 4'h0);
    checks++; if (grid[23] !== 1'b1) begin errors++; $display("FAIL sat_pre lane2_row7 got %b exp 1", grid[23]); end
    @(negedge clk);
    force dut.score_q = 16'hFFFF;
    #1;
    release dut.score_q;
    cycle(1'b0, 1'b0, 4'b0100);
    checks++; if (score !== 16'hFFFF) begin errors++; $display("FAIL sat_score got %h exp %h", score, 16'hFFFF); end
    checks++; if (grid[23] !== 1'b0) begin errors++; $display("FAIL sat_hit_cleared got %b exp 0", grid[23]); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL sat_state got %0d exp 1", state); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (grid !== 32'h0) begin errors++; $display("FAIL async_grid got %h exp 0", grid); end
    checks++; if (score !== 16'h0) begin errors++; $display("FAIL async_score got %h exp 0", score); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL async_state got %0d exp 0", state); end
    checks++; if (rate_reset !== 1'b1) begin errors++; $display("FAIL async_rate_reset got %b exp 1", rate_reset); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL async_game_over got %b exp 0", game_over); end
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b0, 1'b1, 4'h0);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL post_reset_needs_start got %0d exp 0", state); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_spawn();
    test_key_on_tick();
    test_miss();
    test_wrong_key();
    test_window_row6();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
